// File: rtl/ipif_regbank.sv
// Register bank behind the AXI4-Lite IPIF bridge: ID, scratch, W1C interrupts, CTRL/STAT.
// Define IPIF_REGBANK_STAT_SYNC_EN to pass stat_in through a 2-flop synchronizer.
module ipif_regbank #(
    parameter int          C_ADDR_WIDTH = 12,
    parameter int          C_DATA_WIDTH = 32,
    parameter int          C_NUM_CTRL   = 4,
    parameter logic [31:0] C_ID         = 32'h1E6B_0001,
    parameter int          C_IRQ_WIDTH  = 8
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [C_ADDR_WIDTH-3:0]          wr_addr,
    input  logic                             wr_req,
    input  logic [C_DATA_WIDTH/8-1:0]        wr_be,
    input  logic [C_DATA_WIDTH-1:0]          wr_data,
    output logic                             wr_ack,
    input  logic [C_ADDR_WIDTH-3:0]          rd_addr,
    input  logic                             rd_req,
    output logic [C_DATA_WIDTH-1:0]          rd_data,
    output logic                             rd_ack,
    output logic [C_NUM_CTRL*C_DATA_WIDTH-1:0] ctrl_out,
    input  logic [C_NUM_CTRL*C_DATA_WIDTH-1:0] stat_in,
    input  logic [C_IRQ_WIDTH-1:0]           irq_src,
    output logic                             irq
);

    localparam int          AW = C_ADDR_WIDTH - 2;
    localparam int          DW = C_DATA_WIDTH;
    localparam int          NB = DW / 8;
    localparam int          IW = C_IRQ_WIDTH;
    localparam int unsigned NC = C_NUM_CTRL;

    typedef logic [AW-1:0] addr_t;

    logic [DW-1:0]    scratch;
    logic [IW-1:0]    irq_pend;
    logic [IW-1:0]    irq_en;
    logic [IW-1:0]    irq_src_d;
    logic [NC*DW-1:0] ctrl_q;
    logic [NC*DW-1:0] stat_view;

    logic [DW-1:0]    be_mask;
    logic [DW-1:0]    scratch_m;
    logic [DW-1:0]    en_m;
    logic [DW-1:0]    w1c_bits;
    logic [IW-1:0]    pend_nxt;
    logic             wr_hit, wr_scratch, wr_pend, wr_en;
    logic [NC-1:0]    wr_ctrl;
    logic             rd_hit;
    logic [DW-1:0]    rd_val;

`ifdef IPIF_REGBANK_STAT_SYNC_EN
    logic [NC*DW-1:0] stat_meta;
    logic [NC*DW-1:0] stat_sync;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_meta <= '0;
            stat_sync <= '0;
        end else begin
            stat_meta <= stat_in;
            stat_sync <= stat_meta;
        end
    end

    assign stat_view = stat_sync;
`else
    assign stat_view = stat_in;
`endif

    always_comb begin
        be_mask = '0;
        for (int unsigned k = 0; k < NB; k++)
            be_mask[k*8 +: 8] = {8{wr_be[k]}};
    end

    assign scratch_m = (scratch & ~be_mask) | (wr_data & be_mask);
    assign en_m      = (DW'(irq_en) & ~be_mask) | (wr_data & be_mask);
    assign w1c_bits  = wr_data & be_mask;

    // Edge set is OR'd in after the W1C clear so a coincident set wins.
    assign pend_nxt  = (irq_pend & ~(wr_pend ? w1c_bits[IW-1:0] : '0))
                     | (irq_src & ~irq_src_d);

    always_comb begin
        wr_hit     = 1'b0;
        wr_scratch = 1'b0;
        wr_pend    = 1'b0;
        wr_en      = 1'b0;
        wr_ctrl    = '0;
        if (wr_req) begin
            if (wr_addr == addr_t'(0)) wr_hit = 1'b1;
            if (wr_addr == addr_t'(1)) begin wr_hit = 1'b1; wr_scratch = 1'b1; end
            if (wr_addr == addr_t'(2)) begin wr_hit = 1'b1; wr_pend    = 1'b1; end
            if (wr_addr == addr_t'(3)) begin wr_hit = 1'b1; wr_en      = 1'b1; end
            for (int unsigned i = 0; i < NC; i++) begin
                if (wr_addr == addr_t'(4 + i)) begin wr_hit = 1'b1; wr_ctrl[i] = 1'b1; end
                if (wr_addr == addr_t'(8 + i)) wr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_val = '0;
        if (rd_addr == addr_t'(0)) begin rd_hit = 1'b1; rd_val = DW'(C_ID);   end
        if (rd_addr == addr_t'(1)) begin rd_hit = 1'b1; rd_val = scratch;     end
        if (rd_addr == addr_t'(2)) begin rd_hit = 1'b1; rd_val = DW'(irq_pend); end
        if (rd_addr == addr_t'(3)) begin rd_hit = 1'b1; rd_val = DW'(irq_en); end
        for (int unsigned i = 0; i < NC; i++) begin
            if (rd_addr == addr_t'(4 + i)) begin rd_hit = 1'b1; rd_val = ctrl_q[i*DW +: DW];    end
            if (rd_addr == addr_t'(8 + i)) begin rd_hit = 1'b1; rd_val = stat_view[i*DW +: DW]; end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            rd_data   <= '0;
            irq       <= 1'b0;
            scratch   <= '0;
            irq_pend  <= '0;
            irq_en    <= '0;
            irq_src_d <= '0;
            ctrl_q    <= '0;
        end else begin
            wr_ack    <= wr_hit;
            rd_ack    <= rd_req && rd_hit;
            if (rd_req && rd_hit)
                rd_data <= rd_val;
            irq_src_d <= irq_src;
            irq_pend  <= pend_nxt;
            irq       <= |(irq_pend & irq_en);
            if (wr_scratch)
                scratch <= scratch_m;
            if (wr_en)
                irq_en <= en_m[IW-1:0];
            for (int unsigned i = 0; i < NC; i++)
                if (wr_ctrl[i])
                    ctrl_q[i*DW +: DW] <= (ctrl_q[i*DW +: DW] & ~be_mask) | (wr_data & be_mask);
        end
    end

    assign ctrl_out = ctrl_q;

`ifndef SYNTHESIS
    initial begin
        assert ((C_DATA_WIDTH == 32) || (C_DATA_WIDTH == 64))
            else $fatal(1, "ipif_regbank: C_DATA_WIDTH must be 32 or 64");
        assert ((C_NUM_CTRL >= 1) && (C_NUM_CTRL <= 4))
            else $fatal(1, "ipif_regbank: C_NUM_CTRL must be 1..4");
        assert ((C_IRQ_WIDTH >= 1) && (C_IRQ_WIDTH <= C_DATA_WIDTH))
            else $fatal(1, "ipif_regbank: C_IRQ_WIDTH must be 1..C_DATA_WIDTH");
    end
`endif

endmodule

// File: tb/tb_ipif_regbank.sv
// Directed bench for ipif_regbank with hand-computed expectations.
module tb_ipif_regbank;

    logic         aclk = 1'b0;
    logic         areset;
    logic [9:0]   wr_addr;
    logic         wr_req;
    logic [3:0]   wr_be;
    logic [31:0]  wr_data;
    logic         wr_ack;
    logic [9:0]   rd_addr;
    logic         rd_req;
    logic [31:0]  rd_data;
    logic         rd_ack;
    logic [127:0] ctrl_out;
    logic [127:0] stat_in;
    logic [7:0]   irq_src;
    logic         irq;

    int vectors     = 0;
    int miscompares = 0;
    int bad_acks;

    localparam logic [31:0] ID = 32'h1E6B_0001;

    ipif_regbank #(
        .C_ADDR_WIDTH (12),
        .C_DATA_WIDTH (32),
        .C_NUM_CTRL   (4),
        .C_ID         (ID),
        .C_IRQ_WIDTH  (8)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .wr_addr  (wr_addr),
        .wr_req   (wr_req),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack),
        .ctrl_out (ctrl_out),
        .stat_in  (stat_in),
        .irq_src  (irq_src),
        .irq      (irq)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All steps start and end 1 time unit after a rising edge.
    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
        wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1;
        @(posedge aclk); #1;
        wr_req = 1'b0;
        chk({tag, " wr_ack"}, wr_ack, 1);
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
        rd_addr = a; rd_req = 1'b1;
        @(posedge aclk); #1;
        rd_req = 1'b0;
        chk({tag, " rd_ack"}, rd_ack, 1);
        chk({tag, " rd_data"}, rd_data, exp);
    endtask

    initial begin
        areset = 1'b1;
        wr_addr = '0; wr_req = 1'b0; wr_be = '0; wr_data = '0;
        rd_addr = '0; rd_req = 1'b0;
        irq_src = '0;
        stat_in = 128'h44444444_33333333_22222222_11111111;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset wr_ack", wr_ack, 0);
        chk("reset rd_ack", rd_ack, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset irq", irq, 0);
        chk("reset ctrl_out", ctrl_out, 0);
        areset = 1'b0;
        @(posedge aclk); #1;

        rd(10'h000, ID, "read ID");
        rd(10'h001, 32'h0, "read SCRATCH reset");
        rd(10'h004, 32'h0, "read CTRL0 reset");
        @(posedge aclk); #1;
        chk("rd_ack single pulse", rd_ack, 0);
        chk("irq idle", irq, 0);

        wr(10'h001, 32'hDEADBEEF, 4'b0101, "scratch be");
        @(posedge aclk); #1;
        chk("wr_ack single pulse", wr_ack, 0);
        rd(10'h001, 32'h00AD00EF, "scratch be readback");

        wr(10'h006, 32'h12345678, 4'hF, "ctrl2");
        chk("ctrl2 ctrl_out", ctrl_out, 128'h00000000_12345678_00000000_00000000);
        rd(10'h006, 32'h12345678, "ctrl2 readback");

        wr(10'h003, 32'h1, 4'hF, "irq_en");
        rd(10'h003, 32'h1, "irq_en readback");
        irq_src = 8'h01;
        @(posedge aclk); #1;
        chk("irq lags pend", irq, 0);
        irq_src = 8'h00;
        @(posedge aclk); #1;
        chk("irq asserted", irq, 1);
        rd(10'h002, 32'h1, "pend set");
        wr(10'h002, 32'h1, 4'hF, "w1c");
        @(posedge aclk); #1;
        chk("irq cleared", irq, 0);
        rd(10'h002, 32'h0, "pend cleared");

        irq_src = 8'h01;
        @(posedge aclk); #1;
        irq_src = 8'h00;
        @(posedge aclk); #1;
        irq_src = 8'h01;
        wr(10'h002, 32'h1, 4'hF, "w1c vs set");
        rd(10'h002, 32'h1, "set wins");
        chk("irq after set wins", irq, 1);
        irq_src = 8'h00;
        wr(10'h002, 32'h1, 4'hF, "w1c cleanup");
        wr(10'h002, 32'h1, 4'h0, "w1c be0");
        rd(10'h002, 32'h0, "pend after cleanup");

        wr(10'h003, 32'hFFFFFFFF, 4'hF, "irq_en wide");
        rd(10'h003, 32'h000000FF, "irq_en upper bits");
        wr(10'h003, 32'h0, 4'hF, "irq_en clear");
        @(posedge aclk); #1;
        chk("irq none pending", irq, 0);

        rd_addr = 10'h00F; rd_req = 1'b1;
        wr_addr = 10'h00F; wr_req = 1'b1; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        @(posedge aclk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
        bad_acks = 0;
        for (int i = 0; i < 40; i++) begin
            if (rd_ack !== 1'b0 || wr_ack !== 1'b0) bad_acks++;
            @(posedge aclk); #1;
        end
        chk("unmapped no ack", bad_acks, 0);
        chk("unmapped rd_data held", rd_data, 32'h000000FF);
        chk("unmapped ctrl_out", ctrl_out, 128'h00000000_12345678_00000000_00000000);
        rd(10'h001, 32'h00AD00EF, "unmapped scratch intact");

        rd_addr = 10'h001; rd_req = 1'b1;
        wr_addr = 10'h001; wr_req = 1'b1; wr_data = 32'h11111111; wr_be = 4'hF;
        @(posedge aclk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
        chk("same-cycle wr_ack", wr_ack, 1);
        chk("same-cycle rd_ack", rd_ack, 1);
        chk("same-cycle old value", rd_data, 32'h00AD00EF);
        rd(10'h000, ID, "b2b read 0");
        rd(10'h001, 32'h11111111, "b2b read 1");

        wr(10'h000, 32'h0, 4'hF, "write ID");
        rd(10'h000, ID, "ID unchanged");
        wr(10'h008, 32'h0, 4'hF, "write STAT");
        rd(10'h009, 32'h22222222, "stat1");
        rd(10'h00B, 32'h44444444, "stat3");

        stat_in[31:0] = 32'hA5A5A5A5;
`ifdef IPIF_REGBANK_STAT_SYNC_EN
        rd(10'h008, 32'h11111111, "stat0 early");
`else
        rd(10'h008, 32'hA5A5A5A5, "stat0 early");
`endif
        @(posedge aclk); #1;
        rd(10'h008, 32'hA5A5A5A5, "stat0 late");

        rd_addr = 10'h000; rd_req = 1'b1;
        wr_addr = 10'h004; wr_req = 1'b1; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        @(posedge aclk); #1;
        chk("pre-reset rd_ack", rd_ack, 1);
        areset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        #1;
        chk("mid-reset rd_ack", rd_ack, 0);
        chk("mid-reset wr_ack", wr_ack, 0);
        chk("mid-reset rd_data", rd_data, 0);
        chk("mid-reset ctrl_out", ctrl_out, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        bad_acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk); #1;
            if (rd_ack !== 1'b0 || wr_ack !== 1'b0) bad_acks++;
        end
        chk("post-reset no ack", bad_acks, 0);
        rd(10'h001, 32'h0, "scratch after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
